// File: rtl/switch_box_config_loader.sv
// Configuration bitstream loader for the switch-box / PE tile array.
// Collects 5-byte frames (tile id + little-endian 32-bit word) from a byte
// stream, broadcasts the word on config_data and strobes the addressed tile's
// config_en for one cycle. Tile id 8'hFF ends the stream.
module switch_box_config_loader #(
    parameter int NUM_TILES = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [31:0]          config_data,
    output logic [NUM_TILES-1:0] config_en,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_W-1:0]     frames_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_D0,
        S_D1,
        S_D2,
        S_D3,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [7:0]           EOS_ID     = 8'hFF;
    localparam logic [8:0]           TILE_LIMIT = 9'(NUM_TILES);
    localparam logic [NUM_TILES-1:0] EN_BASE    = NUM_TILES'(1);
    localparam logic [CNT_W-1:0]     CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);

    state_t      state;
    state_t      state_next;

    // hdr_id holds the tile id of the frame in flight; data_low collects the
    // three lower data bytes, the top byte is taken straight from in_byte.
    logic [7:0]  hdr_id;
    logic [23:0] data_low;

    logic        xfer;
    logic        session_start;
    logic        frame_complete;
    logic        id_legal;
    logic        data_shift_en;

    // A byte moves only on a valid/ready handshake; start is honoured only
    // when no session is in progress.
    assign xfer           = in_valid && in_ready;
    assign session_start  = start && ((state == S_IDLE) || (state == S_DONE));
    assign frame_complete = xfer && (state == S_D3);
    assign data_shift_en  = xfer && ((state == S_D0) || (state == S_D1) || (state == S_D2));
    assign id_legal       = ({1'b0, hdr_id} < TILE_LIMIT);

    // State register; reset drops any partially received frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the status outputs that follow directly from the state.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    state_next = (in_byte == EOS_ID) ? S_DONE : S_D0;
                end
            end
            S_D0: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    state_next = S_D1;
                end
            end
            S_D1: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    state_next = S_D2;
                end
            end
            S_D2: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    state_next = S_D3;
                end
            end
            S_D3: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                busy       = 1'b1;
                state_next = S_HDR;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = S_HDR;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Frame assembly and the registered write-side outputs. The strobe is
    // loaded on the last data byte so it appears exactly in the WRITE cycle,
    // and falls back to zero on every other cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_id        <= '0;
            data_low      <= '0;
            config_data   <= '0;
            config_en     <= '0;
            error         <= 1'b0;
            frames_loaded <= '0;
        end else begin
            config_en <= '0;

            if (session_start) begin
                hdr_id        <= '0;
                data_low      <= '0;
                error         <= 1'b0;
                frames_loaded <= '0;
            end

            if (xfer && (state == S_HDR)) begin
                hdr_id <= in_byte;
            end

            if (data_shift_en) begin
                data_low <= {in_byte, data_low[23:8]};
            end

            if (frame_complete) begin
                config_data <= {in_byte, data_low};
                if (id_legal) begin
                    config_en <= EN_BASE << hdr_id;
                    if (frames_loaded != CNT_MAX) begin
                        frames_loaded <= frames_loaded + CNT_ONE;
                    end
                end else begin
                    error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Self-checking bench for switch_box_config_loader: a hand-written vector
// table, directed corner cases, and randomized frames checked cycle by cycle
// against a byte-queue reference model.
module tb_switch_box_config_loader;

    localparam int NUM_TILES = 16;
    localparam int CNT_W     = 4;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [7:0]           in_byte;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          config_data;
    logic [NUM_TILES-1:0] config_en;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [CNT_W-1:0]     frames_loaded;

    int errors = 0;
    int checks = 0;

    // Reference model: bytes of the frame in flight plus expected outputs.
    logic [7:0]           m_bytes[$];
    bit                   m_active;
    bit                   m_write;
    bit                   m_done;
    bit                   m_error;
    int                   m_count;
    logic [31:0]          m_data;
    logic [NUM_TILES-1:0] m_en;

    logic [7:0]           tx_q[$];
    logic [NUM_TILES-1:0] pulse_log[$];
    bit                   last_xfer;
    int                   gap_pct   = 0;
    int                   start_pct = 0;
    string                phase     = "init";

    typedef struct {
        bit          st;
        bit          vld;
        logic [7:0]  b;
        bit          exp_ready;
        logic [15:0] exp_en;
        logic [31:0] exp_data;
        bit          exp_busy;
        bit          exp_done;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    switch_box_config_loader #(
        .NUM_TILES(NUM_TILES),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .config_data  (config_data),
        .config_en    (config_en),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .frames_loaded(frames_loaded)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (%s): got %0h, expected %0h", name, phase, actual, expected);
        end
    endtask

    // Log every strobe and confirm it is never multi-hot.
    always @(negedge clk) begin
        if (config_en != '0) begin
            pulse_log.push_back(config_en);
        end
        checkOutput("en_onehot", 64'($countones(config_en) <= 1), 64'd1);
    end

    task automatic checkModel();
        checkOutput("in_ready", 64'(in_ready), 64'(m_active && !m_write));
        checkOutput("config_en", 64'(config_en), 64'(m_en));
        checkOutput("config_data", 64'(config_data), 64'(m_data));
        checkOutput("busy", 64'(busy), 64'(m_active));
        checkOutput("done", 64'(done), 64'(m_done));
        checkOutput("error", 64'(error), 64'(m_error));
        checkOutput("frames_loaded", 64'(frames_loaded), 64'(m_count));
    endtask

    task automatic applyReset();
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h55;
        @(posedge clk);
        #1;
        m_bytes.delete();
        m_active = 0;
        m_write  = 0;
        m_done   = 0;
        m_error  = 0;
        m_count  = 0;
        m_data   = '0;
        m_en     = '0;
        checkModel();
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model by one cycle, compare.
    task automatic applyStimulus(input bit st, input bit vld, input logic [7:0] b);
        bit          xfer;
        logic [7:0]  id;
        start    = st;
        in_valid = vld;
        in_byte  = b;
        xfer      = vld && m_active && !m_write;
        last_xfer = xfer;
        @(posedge clk);
        #1;
        m_en    = '0;
        m_write = 0;
        if (st && !m_active) begin
            m_active = 1;
            m_done   = 0;
            m_error  = 0;
            m_count  = 0;
            m_bytes.delete();
        end else if (xfer) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 1 && b == 8'hFF) begin
                m_active = 0;
                m_done   = 1;
                m_bytes.delete();
            end else if (m_bytes.size() == 5) begin
                id     = m_bytes[0];
                m_data = {m_bytes[4], m_bytes[3], m_bytes[2], m_bytes[1]};
                if (int'(id) < NUM_TILES) begin
                    m_en = NUM_TILES'(1) << id;
                    if (m_count < CNT_SAT) m_count++;
                end else begin
                    m_error = 1;
                end
                m_write = 1;
                m_bytes.delete();
            end
        end
        checkModel();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic loadFrame(input logic [7:0] id, input logic [31:0] word);
        tx_q.delete();
        tx_q.push_back(id);
        tx_q.push_back(word[7:0]);
        tx_q.push_back(word[15:8]);
        tx_q.push_back(word[23:16]);
        tx_q.push_back(word[31:24]);
    endtask

    // Send tx_q with optional random valid gaps and stray start pulses.
    task automatic sendQueue();
        int idx   = 0;
        int guard = 0;
        bit v;
        bit s;
        while (idx < tx_q.size() && guard < 500) begin
            v = ($urandom_range(0, 99) < gap_pct) ? 1'b0 : 1'b1;
            s = ($urandom_range(0, 99) < start_pct) ? 1'b1 : 1'b0;
            applyStimulus(s, v, v ? tx_q[idx] : 8'($urandom));
            if (last_xfer) idx++;
            guard++;
        end
        checkOutput("send_complete", 64'(idx), 64'(tx_q.size()));
    endtask

    task automatic sendFrame(input logic [7:0] id, input logic [31:0] word);
        loadFrame(id, word);
        sendQueue();
    endtask

    task automatic sendEos();
        tx_q.delete();
        tx_q.push_back(8'hFF);
        sendQueue();
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;

        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h0000, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[1] = '{1'b0, 1'b1, 8'h03, 1'b1, 16'h0000, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[2] = '{1'b0, 1'b1, 8'hEF, 1'b1, 16'h0000, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[3] = '{1'b0, 1'b1, 8'hBE, 1'b1, 16'h0000, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[4] = '{1'b0, 1'b1, 8'hAD, 1'b1, 16'h0000, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[5] = '{1'b0, 1'b1, 8'hDE, 1'b0, 16'h0008, 32'hDEADBEEF, 1'b1, 1'b0, 1};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 32'hDEADBEEF, 1'b1, 1'b0, 1};
        vecs[7] = '{1'b0, 1'b1, 8'hFF, 1'b0, 16'h0000, 32'hDEADBEEF, 1'b0, 1'b1, 1};

        phase = "reset";
        applyReset();
        applyReset();

        phase = "table";
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].st, vecs[i].vld, vecs[i].b);
            checkOutput($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d_en", i), 64'(config_en), 64'(vecs[i].exp_en));
            checkOutput($sformatf("vec%0d_data", i), 64'(config_data), 64'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
            checkOutput($sformatf("vec%0d_cnt", i), 64'(frames_loaded), 64'(vecs[i].exp_cnt));
        end

        phase = "tiles";
        applyStimulus(1'b1, 1'b0, 8'h00);
        pulse_log.delete();
        gap_pct = 40;
        sendFrame(8'h00, 32'h01234567);
        sendFrame(8'h0F, 32'h89ABCDEF);
        sendFrame(8'h07, 32'hCAFEF00D);
        sendEos();
        idle(2);
        checkOutput("tiles_pulses", 64'(pulse_log.size()), 64'd3);
        if (pulse_log.size() == 3) begin
            checkOutput("tiles_p0", 64'(pulse_log[0]), 64'h0001);
            checkOutput("tiles_p1", 64'(pulse_log[1]), 64'h8000);
            checkOutput("tiles_p2", 64'(pulse_log[2]), 64'h0080);
        end
        checkOutput("tiles_done", 64'(done), 64'd1);
        checkOutput("tiles_busy", 64'(busy), 64'd0);
        checkOutput("tiles_cnt", 64'(frames_loaded), 64'd3);

        phase = "illegal";
        gap_pct = 0;
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendFrame(8'h10, 32'h44332211);
        checkOutput("illegal_en", 64'(config_en), 64'd0);
        checkOutput("illegal_data", 64'(config_data), 64'h44332211);
        checkOutput("illegal_err", 64'(error), 64'd1);
        checkOutput("illegal_cnt", 64'(frames_loaded), 64'd0);
        sendFrame(8'h05, 32'h12345678);
        checkOutput("after_en", 64'(config_en), 64'h0020);
        checkOutput("after_data", 64'(config_data), 64'h12345678);
        checkOutput("after_cnt", 64'(frames_loaded), 64'd1);
        checkOutput("after_err", 64'(error), 64'd1);

        phase = "reset_mid";
        idle(1);
        loadFrame(8'h09, 32'hDDCCBBAA);
        void'(tx_q.pop_back());
        void'(tx_q.pop_back());
        sendQueue();
        pulse_log.delete();
        applyReset();
        idle(3);
        checkOutput("rst_no_pulse", 64'(pulse_log.size()), 64'd0);
        checkOutput("rst_data", 64'(config_data), 64'd0);
        checkOutput("rst_ready", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendFrame(8'h02, 32'h04030201);
        checkOutput("rst_new_en", 64'(config_en), 64'h0004);
        checkOutput("rst_new_data", 64'(config_data), 64'h04030201);

        phase = "start_d1";
        idle(1);
        tx_q.delete();
        tx_q.push_back(8'h06);
        tx_q.push_back(8'hC1);
        sendQueue();
        applyStimulus(1'b1, 1'b1, 8'hC2);
        tx_q.delete();
        tx_q.push_back(8'hC3);
        tx_q.push_back(8'hC4);
        sendQueue();
        checkOutput("d1_en", 64'(config_en), 64'h0040);
        checkOutput("d1_data", 64'(config_data), 64'hC4C3C2C1);
        checkOutput("d1_cnt", 64'(frames_loaded), 64'd2);
        sendEos();
        checkOutput("d1_done", 64'(done), 64'd1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("restart_done", 64'(done), 64'd0);
        checkOutput("restart_err", 64'(error), 64'd0);
        checkOutput("restart_cnt", 64'(frames_loaded), 64'd0);
        checkOutput("restart_ready", 64'(in_ready), 64'd1);

        phase = "saturate";
        for (int i = 0; i < CNT_SAT + 2; i++) begin
            sendFrame(8'($urandom_range(0, NUM_TILES - 1)), $urandom);
        end
        checkOutput("sat_cnt", 64'(frames_loaded), 64'(CNT_SAT));
        checkOutput("sat_pulse", 64'($countones(config_en)), 64'd1);

        phase = "random";
        applyReset();
        applyStimulus(1'b1, 1'b0, 8'h00);
        gap_pct   = 30;
        start_pct = 10;
        for (int i = 0; i < 40; i++) begin
            sendFrame(8'($urandom_range(0, 20)), $urandom);
        end
        sendEos();
        idle(2);
        checkOutput("rand_done", 64'(done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
